// File: rtl/spike_aer_encoder.sv
// Serialises each accepted spike vector into AER beats {ts, addr} in ascending address order, closed by an EOF beat.
// Latency: first event in chunk k is valid k+1 edges after accept; an empty frame's EOF after N_NEURONS/CHUNK edges.
// Backpressure: output beats hold while m_axis_tready=0; a new frame is accepted only when enabled and idle.
module spike_aer_encoder #(
    parameter int N_NEURONS = 512,
    parameter int CHUNK     = 32,
    parameter int TS_BITS   = 16,
    parameter int ADDR_BITS = $clog2(N_NEURONS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [N_NEURONS-1:0]         s_axis_tspikes,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [TS_BITS+ADDR_BITS-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [31:0]                  frame_count,
    output logic [31:0]                  event_count,
    output logic [ADDR_BITS:0]           last_frame_events
);
    localparam int NCHUNK = N_NEURONS / CHUNK;
    localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int BIT_W  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_EMIT, ST_EOF} state_t;

    state_t                         state, state_nxt;
    logic [N_NEURONS-1:0]           shadow, shadow_nxt;
    logic [CHUNK-1:0]               work, work_nxt, work_clr, cur_chunk;
    logic [CIDX_W-1:0]              chunk_idx, chunk_idx_nxt;
    logic [TS_BITS-1:0]             ts_ctr, ts_ctr_nxt, ts_cur, ts_cur_nxt;
    logic [ADDR_BITS:0]             frame_events, frame_events_nxt, last_fe_nxt;
    logic [TS_BITS+ADDR_BITS-1:0]   tdata_nxt;
    logic                           tvalid_nxt, tlast_nxt, is_last, out_hs;
    logic [31:0]                    frame_count_nxt, event_count_nxt;

    function automatic logic [BIT_W-1:0] lowest_bit(input logic [CHUNK-1:0] v);
        logic [BIT_W-1:0] idx;
        idx = '0;
        for (int i = CHUNK - 1; i >= 0; i--)
            if (v[i]) idx = BIT_W'(i);
        return idx;
    endfunction

    function automatic logic [ADDR_BITS-1:0] event_addr(input logic [CIDX_W-1:0] ci,
                                                        input logic [CHUNK-1:0]  v);
        return ADDR_BITS'(ci) * ADDR_BITS'(CHUNK) + ADDR_BITS'(lowest_bit(v));
    endfunction

    assign s_axis_tready = enable && (state == ST_IDLE);
    assign cur_chunk     = shadow[int'(chunk_idx) * CHUNK +: CHUNK];
    assign is_last       = (chunk_idx == CIDX_W'(NCHUNK - 1));
    assign work_clr      = work & (work - 1'b1);
    assign out_hs        = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            shadow            <= '0;
            work              <= '0;
            chunk_idx         <= '0;
            ts_ctr            <= '0;
            ts_cur            <= '0;
            frame_events      <= '0;
            m_axis_tdata      <= '0;
            m_axis_tvalid     <= 1'b0;
            m_axis_tlast      <= 1'b0;
            frame_count       <= '0;
            event_count       <= '0;
            last_frame_events <= '0;
        end else begin
            state             <= state_nxt;
            shadow            <= shadow_nxt;
            work              <= work_nxt;
            chunk_idx         <= chunk_idx_nxt;
            ts_ctr            <= ts_ctr_nxt;
            ts_cur            <= ts_cur_nxt;
            frame_events      <= frame_events_nxt;
            m_axis_tdata      <= tdata_nxt;
            m_axis_tvalid     <= tvalid_nxt;
            m_axis_tlast      <= tlast_nxt;
            frame_count       <= frame_count_nxt;
            event_count       <= event_count_nxt;
            last_frame_events <= last_fe_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        shadow_nxt       = shadow;
        work_nxt         = work;
        chunk_idx_nxt    = chunk_idx;
        ts_ctr_nxt       = ts_ctr;
        ts_cur_nxt       = ts_cur;
        frame_events_nxt = frame_events;
        tdata_nxt        = m_axis_tdata;
        tvalid_nxt       = m_axis_tvalid;
        tlast_nxt        = m_axis_tlast;
        frame_count_nxt  = frame_count;
        event_count_nxt  = event_count;
        last_fe_nxt      = last_frame_events;
        case (state)
            ST_IDLE: begin
                if (s_axis_tvalid && s_axis_tready) begin
                    shadow_nxt       = s_axis_tspikes;
                    chunk_idx_nxt    = '0;
                    ts_cur_nxt       = ts_ctr;
                    ts_ctr_nxt       = ts_ctr + 1'b1;
                    frame_events_nxt = '0;
                    state_nxt        = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cur_chunk != '0) begin
                    work_nxt   = cur_chunk;
                    tdata_nxt  = {ts_cur, event_addr(chunk_idx, cur_chunk)};
                    tvalid_nxt = 1'b1;
                    state_nxt  = ST_EMIT;
                end else if (is_last) begin
                    tdata_nxt  = {ts_cur, {ADDR_BITS{1'b0}}};
                    tlast_nxt  = 1'b1;
                    tvalid_nxt = 1'b1;
                    state_nxt  = ST_EOF;
                end else begin
                    chunk_idx_nxt = chunk_idx + 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_hs) begin
                    work_nxt         = work_clr;
                    frame_events_nxt = frame_events + 1'b1;
                    event_count_nxt  = event_count + 32'd1;
                    // Next address is loaded on the handshake edge so a chunk drains one beat per cycle
                    if (work_clr != '0) begin
                        tdata_nxt = {ts_cur, event_addr(chunk_idx, work_clr)};
                    end else if (is_last) begin
                        tdata_nxt = {ts_cur, {ADDR_BITS{1'b0}}};
                        tlast_nxt = 1'b1;
                        state_nxt = ST_EOF;
                    end else begin
                        tvalid_nxt    = 1'b0;
                        chunk_idx_nxt = chunk_idx + 1'b1;
                        state_nxt     = ST_SCAN;
                    end
                end
            end
            ST_EOF: begin
                if (out_hs) begin
                    tvalid_nxt      = 1'b0;
                    tlast_nxt       = 1'b0;
                    frame_count_nxt = frame_count + 32'd1;
                    last_fe_nxt     = frame_events;
                    state_nxt       = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_spike_aer_encoder.sv
// Randomised and directed bench for spike_aer_encoder (N=64, CHUNK=16, TS_BITS=4) against a frame-level beat-list model.
module tb_spike_aer_encoder;
    localparam int N  = 64;
    localparam int C  = 16;
    localparam int TB = 4;
    localparam int AB = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            enable = 1'b1;
    logic [N-1:0]    s_axis_tspikes = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [TB+AB-1:0] m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            m_axis_tlast;
    logic [31:0]     frame_count, event_count;
    logic [AB:0]     last_frame_events;

    spike_aer_encoder #(.N_NEURONS(N), .CHUNK(C), .TS_BITS(TB)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_axis_tspikes(s_axis_tspikes), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .frame_count(frame_count), .event_count(event_count),
        .last_frame_events(last_frame_events)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted frame becomes its list of beats; counters follow output handshakes.
    typedef struct { int ts; int addr; bit last; } beat_t;
    beat_t exp_q[$];
    int    ts_model = 0;
    int    m_frames = 0, m_events = 0, m_last = 0, m_frame_ev = 0;
    bit    busy = 0;
    bit    prev_stall = 0;
    logic [TB+AB-1:0] prev_dat;
    logic  prev_last;
    bit    rand_mode = 0;

    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            exp_q.delete();
            ts_model = 0; m_frames = 0; m_events = 0; m_last = 0; m_frame_ev = 0;
            busy = 0; prev_stall = 0;
        end else begin
            check("s_tready", 64'(s_axis_tready), 64'(enable && !busy));
            check("frame_count", 64'(frame_count), 64'(m_frames));
            check("event_count", 64'(event_count), 64'(m_events));
            check("last_frame_events", 64'(last_frame_events), 64'(m_last));
            if (prev_stall) begin
                check("stall_valid", 64'(m_axis_tvalid), 64'd1);
                check("stall_data", 64'(m_axis_tdata), 64'(prev_dat));
                check("stall_last", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (m_axis_tvalid) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    b = exp_q[0];
                    check("beat_data", 64'(m_axis_tdata), 64'(b.ts * 64 + b.addr));
                    check("beat_last", 64'(m_axis_tlast), 64'(b.last));
                    if (m_axis_tready) begin
                        void'(exp_q.pop_front());
                        if (b.last) begin
                            m_frames++; m_last = m_frame_ev; m_frame_ev = 0; busy = 0;
                        end else begin
                            m_events++; m_frame_ev++;
                        end
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_dat   = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (s_axis_tvalid && s_axis_tready) begin
                for (int i = 0; i < N; i++)
                    if (s_axis_tspikes[i]) exp_q.push_back('{ts_model, i, 1'b0});
                exp_q.push_back('{ts_model, 0, 1'b1});
                ts_model = (ts_model + 1) % 16;
                busy = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send_frame(input logic [N-1:0] v);
        bit ok = 0;
        s_axis_tspikes = v;
        s_axis_tvalid  = 1'b1;
        for (int n = 0; n < 3000 && !ok; n++) begin
            @(negedge clk);
            if (s_axis_tready) ok = 1;
        end
        check("accept_in_time", 64'(ok), 64'd1);
        @(posedge clk); #1;
        s_axis_tvalid  = 1'b0;
        s_axis_tspikes = {$urandom, $urandom};
    endtask

    task automatic wait_beat(input bit eof_only, output int edges, output int gaps);
        bit seen = 0;
        edges = 0; gaps = 0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(posedge clk); #1;
            edges++;
            if (m_axis_tvalid && (!eof_only || m_axis_tlast)) seen = 1;
            else if (!m_axis_tvalid) gaps++;
        end
        check("beat_in_time", 64'(seen), 64'd1);
    endtask

    int e1, g1, e2, g2;
    logic [N-1:0] rv;

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_async_valid", 64'(m_axis_tvalid), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_event_count", 64'(event_count), 64'd0);
        check("rst_last_fe", 64'(last_frame_events), 64'd0);
        check("rst_tready_en", 64'(s_axis_tready), 64'd1);
        enable = 1'b0; #1;
        check("rst_tready_dis", 64'(s_axis_tready), 64'd0);
        enable = 1'b1;
        @(posedge clk); #1;

        // Bits 3, 17, 63
        send_frame(64'h8000_0000_0002_0008);
        wait_beat(0, e1, g1);
        check("t1_first_lat", 64'(e1), 64'd1);
        check("t1_first_data", 64'(m_axis_tdata), 64'd3);
        wait_beat(1, e2, g2);
        check("t1_eof_lat", 64'(e1 + e2), 64'd7);
        check("t1_gaps", 64'(g1 + g2), 64'd3);
        @(posedge clk); #1;
        check("t1_event_count", 64'(event_count), 64'd3);
        check("t1_frame_count", 64'(frame_count), 64'd1);
        check("t1_last_fe", 64'(last_frame_events), 64'd3);

        // Empty frame
        send_frame(64'h0);
        wait_beat(1, e1, g1);
        check("t2_eof_lat", 64'(e1), 64'd4);
        check("t2_eof_data", 64'(m_axis_tdata), 64'd64);
        @(posedge clk); #1;
        check("t2_event_count", 64'(event_count), 64'd3);
        check("t2_last_fe", 64'(last_frame_events), 64'd0);
        check("t2_frame_count", 64'(frame_count), 64'd2);

        // All ones
        send_frame({N{1'b1}});
        wait_beat(0, e1, g1);
        check("t3_first_lat", 64'(e1), 64'd1);
        check("t3_first_data", 64'(m_axis_tdata), 64'd128);
        wait_beat(1, e2, g2);
        check("t3_eof_lat", 64'(e1 + e2), 64'd68);
        check("t3_gaps", 64'(g1 + g2), 64'd3);
        @(posedge clk); #1;
        check("t3_last_fe", 64'(last_frame_events), 64'd64);
        check("t3_event_count", 64'(event_count), 64'd67);

        // enable dropped mid-frame: frame still completes
        send_frame(64'h8001_0000_0000_0100);
        enable = 1'b0;
        wait_beat(1, e1, g1);
        @(posedge clk); #1;
        check("t4_frame_count", 64'(frame_count), 64'd4);
        check("t4_tready_blocked", 64'(s_axis_tready), 64'd0);
        enable = 1'b1;

        // Random frames under random backpressure
        rand_mode = 1;
        for (int j = 0; j < 20; j++) begin
            case (j % 4)
                0: rv = {$urandom, $urandom};
                1: rv = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                2: rv = (j % 8 == 2) ? '0 : (64'd1 << $urandom_range(0, 63));
                default: rv = ~({$urandom, $urandom} & {$urandom, $urandom});
            endcase
            send_frame(rv);
        end
        for (int n = 0; n < 20000 && (exp_q.size() != 0 || busy); n++) begin
            @(posedge clk); #1;
        end
        check("t5_drained", 64'(exp_q.size()), 64'd0);
        rand_mode = 0;
        @(posedge clk); #1;

        // Reset during EMIT of an all-ones frame
        send_frame({N{1'b1}});
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t6_event_count", 64'(event_count), 64'd0);
        check("t6_frame_count", 64'(frame_count), 64'd0);
        check("t6_last_fe", 64'(last_frame_events), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("t6_tready", 64'(s_axis_tready), 64'd1);
        @(posedge clk); #1;

        // 17 single-spike frames: timestamp wraps after 15
        for (int j = 0; j < 17; j++) begin
            send_frame(64'h20);
            wait_beat(0, e1, g1);
            check("t7_ts", 64'(m_axis_tdata), 64'((j % 16) * 64 + 5));
            check("t7_lat", 64'(e1), 64'd1);
            wait_beat(1, e2, g2);
            @(posedge clk); #1;
        end
        check("t7_frame_count", 64'(frame_count), 64'd17);
        check("t7_event_count", 64'(event_count), 64'd17);
        check("t7_last_fe", 64'(last_frame_events), 64'd1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
